// File: rtl/instr_fetch_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package instr_fetch_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned RESET_PC_DEF = 0;

endpackage

// File: rtl/prog_mem.sv
// Single-clock program RAM: one write port, one registered read port, no reset.
module prog_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loads a program into RAM, then streams words
// sequentially with stall, redirect and wrap-around.
module instr_fetch_unit
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              run,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              running
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              running_q, running_d;
  logic              has_data_q, has_data_d;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    has_data_d    = has_data_q;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    unique case (state_q)
      LOAD: begin
        mem_we        = load_en & ~reset;
        instr_valid_d = 1'b0;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          state_d       = LOAD;
          instr_valid_d = 1'b0;
        end else if (redirect_valid) begin
          fetch_pc_d    = redirect_pc;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          mem_re        = ~reset;
          instr_pc_d    = fetch_pc_q;
          instr_valid_d = 1'b1;
          has_data_d    = 1'b1;
          fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        end
      end
    endcase
    running_d = (state_d == RUN);
  end

  // instr is the RAM's own read register; has_data_q masks it to zero
  // after reset since the RAM itself is never cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LOAD;
      fetch_pc_q    <= ADDR_W'(RESET_PC);
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      running_q     <= 1'b0;
      has_data_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      running_q     <= running_d;
      has_data_q    <= has_data_d;
    end
  end

  prog_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_prog_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(load_addr),
    .wdata(load_data),
    .re   (mem_re),
    .raddr(fetch_pc_q),
    .rdata(mem_rdata)
  );

  assign instr       = has_data_q ? mem_rdata : '0;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign running     = running_q;

endmodule
